// File: rtl/ahb_fifo_reader.sv
// AHB-Lite slave: DATA reads pop a first-word-fall-through FIFO, plus STATUS and ERRCNT registers.
// Optional empty-read timeout is enabled by defining AHB_FIFO_READER_TIMEOUT_EN.
module ahb_fifo_reader #(
  parameter int DATA_W  = 32,
  parameter int CNT_W   = 5,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hsel,
  input  logic [3:0]        haddr,
  input  logic [1:0]        htrans,
  input  logic              hwrite,
  input  logic              hready,
  input  logic [DATA_W-1:0] hwdata,
  output logic [DATA_W-1:0] hrdata,
  output logic              hreadyout,
  output logic              hresp,
  output logic              fifo_rd_en,
  input  logic [DATA_W-1:0] fifo_rd_data,
  input  logic              fifo_empty,
  input  logic [CNT_W-1:0]  fifo_count
);

  typedef enum logic [1:0] {IDLE, WAIT, ERR1, ERR2} state_t;

  localparam logic [1:0] A_DATA   = 2'd0;
  localparam logic [1:0] A_STATUS = 2'd1;
  localparam logic [1:0] A_ERRCNT = 2'd2;

  state_t     state;
  logic       dp_vld;
  logic [1:0] dp_addr;
  logic       dp_write;
  logic [7:0] errcnt;

  logic take;
  logic take_err;
  logic dp_data_rd;
  logic errcnt_clr;
  logic wait_to;
  logic err_inc;
  logic unused_ok;

  assign unused_ok = &{1'b0, haddr[1:0], htrans[0], hwdata};

  assign take       = hsel && htrans[1] && hready && hreadyout;
  assign take_err   = take && (haddr[3:2] == A_DATA) && hwrite;
  assign dp_data_rd = (state == IDLE) && dp_vld && !dp_write && (dp_addr == A_DATA);
  assign errcnt_clr = (state == IDLE) && dp_vld && dp_write && (dp_addr == A_ERRCNT);

`ifdef AHB_FIFO_READER_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  // Counts wait-state cycles of the current DATA read, including the first one spent in IDLE.
  logic [WAIT_W-1:0] wait_cnt;
  assign wait_to = (state == WAIT) && fifo_empty && (wait_cnt >= WAIT_W'(TIMEOUT - 1));
`else
  assign wait_to = 1'b0;
`endif

  assign err_inc = take_err || wait_to;

  always_comb begin
    hrdata     = '0;
    hreadyout  = 1'b1;
    hresp      = 1'b0;
    fifo_rd_en = 1'b0;
    case (state)
      IDLE: begin
        if (dp_vld && !dp_write) begin
          case (dp_addr)
            A_DATA: begin
              if (fifo_empty) begin
                hreadyout = 1'b0;
              end else begin
                hrdata     = fifo_rd_data;
                fifo_rd_en = 1'b1;
              end
            end
            A_STATUS: hrdata = DATA_W'({fifo_count, fifo_empty});
            A_ERRCNT: hrdata = DATA_W'(errcnt);
            default:  hrdata = '0;
          endcase
        end
      end
      WAIT: begin
        if (fifo_empty) begin
          hreadyout = 1'b0;
        end else begin
          hrdata     = fifo_rd_data;
          fifo_rd_en = 1'b1;
        end
      end
      ERR1: begin
        hreadyout = 1'b0;
        hresp     = 1'b1;
      end
      ERR2: hresp = 1'b1;
      default: hreadyout = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      dp_vld   <= 1'b0;
      dp_addr  <= 2'd0;
      dp_write <= 1'b0;
      errcnt   <= 8'd0;
`ifdef AHB_FIFO_READER_TIMEOUT_EN
      wait_cnt <= '0;
`endif
    end else begin
      // A clear from an ERRCNT write wins over a same-cycle error.
      if (errcnt_clr) begin
        errcnt <= 8'd0;
      end else if (err_inc && (errcnt != 8'hFF)) begin
        errcnt <= errcnt + 8'd1;
      end

      case (state)
        IDLE: begin
          if (dp_data_rd && fifo_empty) begin
            state <= WAIT;
`ifdef AHB_FIFO_READER_TIMEOUT_EN
            wait_cnt <= WAIT_W'(1);
`endif
          end
        end
        WAIT: begin
          if (!fifo_empty) begin
            state <= IDLE;
          end else if (wait_to) begin
            state <= ERR1;
          end
`ifdef AHB_FIFO_READER_TIMEOUT_EN
          else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
`endif
        end
        ERR1:    state <= ERR2;
        ERR2:    state <= IDLE;
        default: state <= IDLE;
      endcase

      // Address phases are taken in the same cycle the previous data phase completes.
      if (hreadyout) begin
        dp_vld <= take;
        if (take) begin
          dp_addr  <= haddr[3:2];
          dp_write <= hwrite;
          if (take_err) state <= ERR1;
        end
      end
    end
  end

endmodule
